// File: rtl/rps_input_ctrl_if.sv
// rps_input_ctrl_if: button inputs and round results of the rock/paper/scissors input controller
//   start, p1_btn, p2_btn            : driven by master, sampled by slave
//   p1/p2_choice, p1/p2_locked, busy,
//   result_valid, timeout            : driven by slave
interface rps_input_ctrl_if;
  logic       start;
  logic [2:0] p1_btn;
  logic [2:0] p2_btn;
  logic [1:0] p1_choice;
  logic [1:0] p2_choice;
  logic       p1_locked;
  logic       p2_locked;
  logic       busy;
  logic       result_valid;
  logic       timeout;
  modport master (
    output start, p1_btn, p2_btn,
    input  p1_choice, p2_choice, p1_locked, p2_locked, busy, result_valid, timeout
  );
  modport slave (
    input  start, p1_btn, p2_btn,
    output p1_choice, p2_choice, p1_locked, p2_locked, busy, result_valid, timeout
  );
endinterface

// File: rtl/rps_input_ctrl.sv
// rps_input_ctrl: debounces two players' buttons and locks one choice per player per round
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of rps_input_ctrl_if (start/buttons in, choices/locks/status out)
module rps_input_ctrl #(
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 4096
) (
  input logic            clk,
  input logic            reset,
  rps_input_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
  state_t r_state, w_next;
  logic [1:0][2:0]    w_raw, r_prev, r_deb, r_deb_d;
  logic [1:0][DW-1:0] r_cnt;
  logic [1:0][1:0]    r_choice;
  logic [1:0]         r_locked, w_ev, w_lock;
  logic [TW-1:0]      r_tcnt;
  logic               r_timeout, w_to;
  assign w_raw = {bus.p2_btn, bus.p1_btn};
  // an event is an edge of the debounced vector out of 000 into a single button
  always_comb begin
    w_ev = '0;
    for (int i = 0; i < 2; i++) w_ev[i] = (r_deb_d[i] == 3'b000) && $onehot(r_deb[i]);
  end
  assign w_lock = w_ev & ~r_locked & {2{r_state == COLLECT}};
  // a lock completing on the terminal timeout cycle takes priority over the abort
  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    if (r_state == IDLE && bus.start) w_next = COLLECT;
    else if (r_state == REPORT) w_next = IDLE;
    else if (r_state == COLLECT && &(r_locked | w_lock)) w_next = REPORT;
    else if (r_state == COLLECT && r_tcnt == TMAX) begin
      w_next = IDLE;
      w_to   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_cnt   <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_prev[i]  <= w_raw[i];
        r_cnt[i]   <= (w_raw[i] != r_prev[i]) ? '0 : (r_cnt[i] == DMAX ? r_cnt[i] : r_cnt[i] + 1'b1);
        r_deb[i]   <= (w_raw[i] == r_prev[i] && r_cnt[i] == DMAX) ? w_raw[i] : r_deb[i];
        r_deb_d[i] <= r_deb[i];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timeout <= 1'b0;
      r_tcnt    <= '0;
      r_locked  <= '0;
      r_choice  <= '0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_to;
      r_tcnt    <= (r_state == COLLECT) ? r_tcnt + 1'b1 : '0;
      if (r_state == IDLE && bus.start) begin
        r_locked <= '0;
        r_choice <= '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (w_lock[i]) begin
            r_locked[i] <= 1'b1;
            r_choice[i] <= {r_deb[i][2] | r_deb[i][1], r_deb[i][2] | r_deb[i][0]};
          end
        end
      end
    end
  end
  assign bus.p1_choice    = r_choice[0];
  assign bus.p2_choice    = r_choice[1];
  assign bus.p1_locked    = r_locked[0];
  assign bus.p2_locked    = r_locked[1];
  assign bus.busy         = r_state != IDLE;
  assign bus.result_valid = r_state == REPORT;
  assign bus.timeout      = r_timeout;
endmodule
